// File: rtl/bitbakery_serial_rx_pkg.sv
// Shared definitions for the BitBakery 8E1 serial link: frame geometry,
// byte-FSM state encoding and the parity rule used by both link ends.
package bitbakery_serial_rx_pkg;

  localparam int FRAME_BYTES = 67;
  localparam int MAP_BYTES   = 64;
  localparam int IDX_W       = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  function automatic logic parity_good(input logic [7:0] data, input logic par);
    return ~(^data ^ par);
  endfunction

endpackage

// File: rtl/bitbakery_rx_byte.sv
// 8E1 byte receiver: input synchronizer, mid-bit sampling counters, byte FSM
// and parity/stop check. Delivers one registered byte per frame slot.
module bitbakery_rx_byte
  import bitbakery_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       ok,
  output logic       line_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic             prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             par_q;

  logic rx, fall, tick;
  assign rx        = sync_q[1];
  assign fall      = prev_q & ~rx;
  assign tick      = (cnt_q == '0);
  assign line_idle = (state_q == ST_IDLE) && rx;

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (tick) state_d = rx ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours (the synchronizer chain relies on it).
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      rx_data    <= '0;
      byte_valid <= 1'b0;
      ok         <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], entrada_serial};
      prev_q     <= rx;
      state_q    <= state_d;
      byte_valid <= 1'b0;

      // Idle preloads half a bit so the first sample lands mid start bit.
      if (state_q == ST_IDLE) cnt_q <= HALF_LOAD;
      else if (tick)          cnt_q <= FULL_LOAD;
      else                    cnt_q <= cnt_q - 1'b1;

      if (tick) begin
        unique case (state_q)
          ST_START: bit_q <= '0;
          ST_DATA: begin
            shift_q <= {rx, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
          end
          ST_PARITY: par_q <= rx;
          ST_STOP: begin
            rx_data    <= shift_q;
            ok         <= parity_good(shift_q, par_q) & rx;
            byte_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/bitbakery_serial_rx.sv
// Frame assembler: collects 67 bytes into shadow registers and publishes them
// atomically at the idle gap only when the whole frame arrived intact.
module bitbakery_serial_rx
  import bitbakery_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int IDLE_BITS    = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         entrada_serial,
  output logic [7:0]   D0,
  output logic [7:0]   D1,
  output logic [7:0]   D2,
  output logic [511:0] map_obstacles,
  output logic         pronto,
  output logic         erro
);

  localparam int GAP   = IDLE_BITS * CLKS_PER_BIT;
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP - 1);
  localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(FRAME_BYTES);

  logic [7:0]       rx_data;
  logic             byte_valid, ok, line_idle;
  logic [IDX_W-1:0] idx_q;
  logic             bad_q;
  logic [GAP_W-1:0] gap_q;
  logic [7:0]       shadow [FRAME_BYTES];
  logic             gap_hit;

  bitbakery_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .rx_data        (rx_data),
    .byte_valid     (byte_valid),
    .ok             (ok),
    .line_idle      (line_idle)
  );

  assign gap_hit = line_idle && (gap_q == GAP_LAST);

  // NOTE: the shadow array is deliberately not reset; a clear index makes
  // stale contents unreachable, and skipping reset keeps it plain RAM/flops.
  always_ff @(posedge clock) begin
    if (byte_valid && idx_q != FULL_IDX) shadow[idx_q] <= rx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q         <= '0;
      bad_q         <= 1'b0;
      gap_q         <= '0;
      D0            <= '0;
      D1            <= '0;
      D2            <= '0;
      map_obstacles <= '0;
      pronto        <= 1'b0;
      erro          <= 1'b0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;

      if (!line_idle || gap_hit) gap_q <= '0;
      else                       gap_q <= gap_q + 1'b1;

      if (gap_hit) begin
        if (idx_q == FULL_IDX && !bad_q) begin
          D0 <= shadow[0];
          D1 <= shadow[1];
          D2 <= shadow[2];
          for (int k = 0; k < MAP_BYTES; k++) map_obstacles[8*k +: 8] <= shadow[3+k];
          pronto <= 1'b1;
        end else if (idx_q != '0) begin
          erro <= 1'b1;
        end
        idx_q <= '0;
        bad_q <= 1'b0;
      end else if (byte_valid) begin
        // Overflow bytes only poison the frame; the index saturates.
        if (idx_q == FULL_IDX) begin
          bad_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
          if (!ok) bad_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Self-checking bench: table-driven frames, random frames against a
// frame-level model, plus glitch and mid-byte reset sequences.
module tb_bitbakery_serial_rx;

  localparam int C  = 8;
  localparam int IB = 2;

  logic         clock;
  logic         reset;
  logic         entrada_serial;
  logic [7:0]   D0, D1, D2;
  logic [511:0] map_obstacles;
  logic         pronto, erro;

  bitbakery_serial_rx #(.CLKS_PER_BIT(C), .IDLE_BITS(IB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .D0             (D0),
    .D1             (D1),
    .D2             (D2),
    .map_obstacles  (map_obstacles),
    .pronto         (pronto),
    .erro           (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tot_pronto = 0;
  int tot_erro = 0;
  int pulse_cyc = 0;
  int end_cyc = 0;
  bit both_seen = 1'b0;

  logic [7:0]   fb [70];
  logic [7:0]   exp_d0, exp_d1, exp_d2;
  logic [511:0] exp_map;

  typedef struct {
    int         len;
    logic [7:0] d0, d1, d2, ofs;
    int         kind;     // 0 none, 1 parity flipped, 2 stop bit low
    int         bad_idx;
  } vec_t;

  vec_t vecs [7];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (pronto) begin tot_pronto++; pulse_cyc = cyc; end
      if (erro)   begin tot_erro++;   pulse_cyc = cyc; end
      if (pronto && erro) both_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    entrada_serial = v;
    repeat (C) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit flip_par, input bit low_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ flip_par);
    drive_bit(~low_stop);
  endtask

  task automatic fill_pattern(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] ofs);
    fb[0] = d0; fb[1] = d1; fb[2] = d2;
    for (int i = 3; i < 70; i++) fb[i] = 8'(i - 3) + ofs;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_D0"}, D0, exp_d0);
    check({tag, "_D1"}, D1, exp_d1);
    check({tag, "_D2"}, D2, exp_d2);
    check({tag, "_map"}, map_obstacles, exp_map);
  endtask

  // Frame-level model: a frame publishes only if it has exactly 67 bytes and
  // none was corrupted; any other non-empty frame is reported as discarded.
  task automatic run_frame(input string tag, input int len, input int kind,
                           input int bad_idx, input int gap_bits);
    int  p0, e0, lat;
    bit  good;
    p0 = tot_pronto;
    e0 = tot_erro;
    for (int i = 0; i < len; i++)
      send_byte(fb[i], (kind == 1) && (i == bad_idx), (kind == 2) && (i == bad_idx));
    end_cyc = cyc;
    entrada_serial = 1'b1;
    repeat (gap_bits * C) @(negedge clock);
    good = (len == 67) && (kind == 0);
    if (good) begin
      exp_d0 = fb[0]; exp_d1 = fb[1]; exp_d2 = fb[2];
      for (int k = 0; k < 64; k++) exp_map[8*k +: 8] = fb[3+k];
    end
    check({tag, "_pronto_count"}, 512'(tot_pronto - p0), good ? 512'd1 : 512'd0);
    check({tag, "_erro_count"}, 512'(tot_erro - e0), (!good && len > 0) ? 512'd1 : 512'd0);
    if (tot_pronto - p0 + tot_erro - e0 == 1) begin
      lat = pulse_cyc - end_cyc;
      check({tag, "_latency_in_window"}, 512'(lat >= 12 && lat <= 20), 512'd1);
    end
    check_outputs(tag);
  endtask

  initial begin
    vecs[0] = '{67, 8'hA5, 8'h3C, 8'h01, 8'h00, 0, 0};
    vecs[1] = '{67, 8'h5A, 8'hC3, 8'h10, 8'h07, 0, 0};
    vecs[2] = '{67, 8'h11, 8'h22, 8'h33, 8'h20, 1, 10};
    vecs[3] = '{67, 8'h44, 8'h55, 8'h66, 8'h30, 2, 66};
    vecs[4] = '{67, 8'h77, 8'h88, 8'h99, 8'h50, 0, 0};
    vecs[5] = '{40, 8'hDE, 8'hAD, 8'hBE, 8'h60, 0, 0};
    vecs[6] = '{70, 8'hCA, 8'hFE, 8'hF0, 8'h70, 0, 0};

    exp_d0 = '0; exp_d1 = '0; exp_d2 = '0; exp_map = '0;
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs("reset");
    check("reset_pronto", 512'(pronto), 512'd0);
    check("reset_erro", 512'(erro), 512'd0);
    reset = 1'b0;

    // Idle line from power-up: gaps with an empty frame stay silent.
    repeat (6 * C) @(negedge clock);
    check("powerup_idle_pulses", 512'(tot_pronto + tot_erro), 512'd0);

    for (int t = 0; t < 7; t++) begin
      fill_pattern(vecs[t].d0, vecs[t].d1, vecs[t].d2, vecs[t].ofs);
      run_frame($sformatf("vec%0d", t), vecs[t].len, vecs[t].kind, vecs[t].bad_idx, 4);
      if (t == 0) begin
        check("vec0_map_byte1", 512'(map_obstacles[15:8]), 512'h01);
        check("vec0_map_byte63", 512'(map_obstacles[511:504]), 512'h3F);
      end
    end

    for (int r = 0; r < 3; r++) begin
      int kind, bidx;
      for (int i = 0; i < 70; i++) fb[i] = 8'($urandom);
      kind = (r == 0) ? 0 : int'($urandom_range(0, 2));
      bidx = int'($urandom_range(0, 66));
      run_frame($sformatf("rand%0d", r), 67, kind, bidx, 4);
    end

    // Short low glitch: sampled high at mid start bit, so no byte at all.
    begin
      int p0, e0;
      p0 = tot_pronto; e0 = tot_erro;
      entrada_serial = 1'b0;
      repeat (3) @(negedge clock);
      entrada_serial = 1'b1;
      repeat (6 * C) @(negedge clock);
      check("glitch_pulses", 512'(tot_pronto - p0 + tot_erro - e0), 512'd0);
      check_outputs("glitch");
    end

    // Reset in the middle of byte 20 wipes outputs and the partial frame.
    begin
      int p0, e0;
      fill_pattern(8'h0F, 8'hF0, 8'h81, 8'h40);
      for (int i = 0; i < 20; i++) send_byte(fb[i], 1'b0, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      entrada_serial = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      exp_d0 = '0; exp_d1 = '0; exp_d2 = '0; exp_map = '0;
      check_outputs("midreset");
      reset = 1'b0;
      p0 = tot_pronto; e0 = tot_erro;
      repeat (6 * C) @(negedge clock);
      check("midreset_idle_pulses", 512'(tot_pronto - p0 + tot_erro - e0), 512'd0);
      run_frame("after_reset", 67, 0, 0, 4);
    end

    check("pulse_exclusive", 512'(both_seen), 512'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
